// File: rtl/rom_burst_reader.sv
// rom_burst_reader: burst reader for a registered 16x4 ROM, emits words as a valid/ready stream
module rom_burst_reader #(
  parameter int ADDR_W = 4,
  parameter int DATA_W = 4
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic              start,
  input  logic [ADDR_W-1:0] base_addr,
  input  logic [ADDR_W:0]   length,
  output logic              busy,
  output logic              done,
  output logic              rom_en,
  output logic [ADDR_W-1:0] rom_addr,
  input  logic [DATA_W-1:0] rom_data,
  output logic              out_valid,
  output logic [DATA_W-1:0] out_data,
  output logic              out_last,
  input  logic              out_ready
);
  typedef enum logic [1:0] {IDLE, RUN, FIN} state_t;
  state_t state, state_nx;
  logic [ADDR_W-1:0] addr_q;
  logic [ADDR_W:0] iss_left, out_left;
  logic inflight, rd_ptr, wr_ptr, pop;
  logic [1:0] occ;
  logic [DATA_W-1:0] buf_q [2];
  // next state and all outputs; issue only if the result is guaranteed a buffer slot
  always_comb begin
    state_nx = state;
    if (state == IDLE && start) state_nx = (length == '0) ? FIN : RUN;
    else if (state == RUN && pop && out_last) state_nx = FIN;
    else if (state == FIN) state_nx = IDLE;
    out_valid = state == RUN && occ != 2'd0;
    pop = out_valid && out_ready;
    out_last = out_valid && out_left == 1;
    out_data = buf_q[rd_ptr];
    rom_en = state == RUN && iss_left != '0 &&
             ({1'b0, occ} + {2'b0, inflight}) < (3'd2 + {2'b0, pop});
    rom_addr = addr_q;
    busy = state != IDLE;
    done = state == FIN;
  end
  // state register plus read-address and word counters
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state <= IDLE;
      addr_q <= '0;
      iss_left <= '0;
      out_left <= '0;
      inflight <= 1'b0;
    end else begin
      state <= state_nx;
      inflight <= rom_en;
      if (state == IDLE && start) begin
        addr_q <= base_addr;
        iss_left <= length;
        out_left <= length;
      end else begin
        if (rom_en) addr_q <= addr_q + 1'b1;
        if (rom_en) iss_left <= iss_left - 1'b1;
        if (pop) out_left <= out_left - 1'b1;
      end
    end
  end
  // two-entry fifo capturing ROM data the cycle after each read
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      buf_q[0] <= '0;
      buf_q[1] <= '0;
      wr_ptr <= 1'b0;
      rd_ptr <= 1'b0;
      occ <= 2'd0;
    end else begin
      if (inflight) buf_q[wr_ptr] <= rom_data;
      if (inflight) wr_ptr <= ~wr_ptr;
      if (pop) rd_ptr <= ~rd_ptr;
      occ <= occ + {1'b0, inflight} - {1'b0, pop};
    end
  end
endmodule

// File: tb/tb_rom_burst_reader.sv
// tb_rom_burst_reader: directed checks of rom_burst_reader against a ~addr ROM model
module tb_rom_burst_reader;
  logic clk = 0, rst_n = 0, start = 0, out_ready = 0;
  logic [3:0] base_addr = 0;
  logic [4:0] length = 0;
  logic busy, done, rom_en, out_valid, out_last;
  logic [3:0] rom_addr, out_data, rom_data;
  int n_cmp = 0, n_bad = 0;
  int n_iss, n_pop, n_done, n_last, first_en, last_en, first_val, done_cyc, busy_at_done, max_out;
  int iss_at9, en_at9, data_at9;

  rom_burst_reader dut (
    .clk(clk), .rst_n(rst_n), .start(start), .base_addr(base_addr), .length(length),
    .busy(busy), .done(done), .rom_en(rom_en), .rom_addr(rom_addr), .rom_data(rom_data),
    .out_valid(out_valid), .out_data(out_data), .out_last(out_last), .out_ready(out_ready)
  );

  always #5 clk = ~clk;

  always @(posedge clk) if (rom_en) rom_data <= ~rom_addr;

  task automatic chk(input string tag, input int got, input int exp);
    n_cmp++;
    if (got !== exp) begin
      n_bad++;
      $display("FAIL %s: got %0d expected %0d", tag, got, exp);
    end
  endtask

  task automatic chk_idle_outputs(input string tag);
    chk({tag, "_busy"}, int'(busy), 0);
    chk({tag, "_done"}, int'(done), 0);
    chk({tag, "_rom_en"}, int'(rom_en), 0);
    chk({tag, "_valid"}, int'(out_valid), 0);
    chk({tag, "_last"}, int'(out_last), 0);
    chk({tag, "_rom_addr"}, int'(rom_addr), 0);
    chk({tag, "_data"}, int'(out_data), 0);
  endtask

  // mode 0: ready high, 1: ready low in cycles 3..9, 2: random ready, 3: ready high + stray start in cycle 2
  task automatic burst(input logic [3:0] b, input logic [4:0] l, input int mode);
    logic [3:0] pd;
    logic pl, hold;
    int k;
    n_iss = 0; n_pop = 0; n_done = 0; n_last = 0; first_en = -1; last_en = -1;
    first_val = -1; done_cyc = -1; busy_at_done = -1; max_out = 0;
    iss_at9 = -1; en_at9 = -1; data_at9 = -1;
    hold = 0; pd = 0; pl = 0;
    @(posedge clk); #1;
    start = 1; base_addr = b; length = l; out_ready = 1;
    for (k = 1; k <= 200; k++) begin
      @(posedge clk); #1;
      start = (mode == 3 && k == 2);
      if (mode == 3 && k == 2) begin
        base_addr = 0;
        length = 3;
      end
      out_ready = (mode == 1) ? !(k >= 3 && k <= 9) : (mode == 2) ? 1'($urandom_range(0, 1)) : 1'b1;
      @(negedge clk);
      if (hold) begin
        chk("hold_valid", int'(out_valid), 1);
        chk("hold_data", int'(out_data), int'(pd));
        chk("hold_last", int'(out_last), int'(pl));
      end
      hold = out_valid && !out_ready;
      pd = out_data;
      pl = out_last;
      if (rom_en) begin
        chk("rom_addr", int'(rom_addr), int'(4'(b + n_iss)));
        if (first_en < 0) first_en = k;
        last_en = k;
        n_iss++;
      end
      if (out_valid && first_val < 0) first_val = k;
      if (out_valid && out_ready) begin
        chk("out_data", int'(out_data), int'(4'(~(b + n_pop))));
        chk("out_last", int'(out_last), int'(n_pop == int'(l) - 1));
        if (out_last) n_last++;
        n_pop++;
      end
      if (n_iss - n_pop > max_out) max_out = n_iss - n_pop;
      if (k == 9) begin
        iss_at9 = n_iss;
        en_at9 = int'(rom_en);
        data_at9 = int'(out_data);
      end
      if (done) begin
        n_done++;
        done_cyc = k;
        busy_at_done = int'(busy);
      end
      if (done_cyc > 0 && k >= done_cyc + 3) break;
    end
    chk("words", n_pop, int'(l));
    chk("reads", n_iss, int'(l));
    chk("done_pulses", n_done, 1);
    chk("no_overflow", int'(max_out <= 2), 1);
    chk("busy_after", int'(busy), 0);
  endtask

  initial begin
    repeat (3) @(posedge clk);
    @(negedge clk);
    chk_idle_outputs("rst_hold");
    rst_n = 1;

    // asynchronous reset mid-burst
    @(posedge clk); #1;
    start = 1; base_addr = 5; length = 8; out_ready = 1;
    @(posedge clk); #1;
    start = 0;
    repeat (3) @(posedge clk);
    @(negedge clk); #2;
    chk("pre_rst_valid", int'(out_valid), 1);
    rst_n = 0;
    #1;
    chk_idle_outputs("rst_async");
    repeat (2) begin
      @(negedge clk);
      chk("rst_no_en", int'(rom_en), 0);
      chk("rst_no_valid", int'(out_valid), 0);
    end
    rst_n = 1;

    // basic burst with address wrap
    burst(4'd14, 5'd4, 0);
    chk("t1_first_en", first_en, 1);
    chk("t1_last_en", last_en, 4);
    chk("t1_first_valid", first_val, 3);
    chk("t1_done_cyc", done_cyc, 7);
    chk("t1_busy_done", busy_at_done, 1);

    // backpressure
    burst(4'd2, 5'd6, 1);
    chk("t2_iss_at9", iss_at9, 2);
    chk("t2_en_at9", en_at9, 0);
    chk("t2_data_at9", data_at9, 13);
    chk("t2_done_cyc", done_cyc, 16);

    // zero length
    burst(4'd7, 5'd0, 0);
    chk("t3_done_cyc", done_cyc, 1);
    chk("t3_busy_done", busy_at_done, 1);
    chk("t3_no_valid", first_val, -1);

    // start while busy is ignored
    burst(4'd5, 5'd5, 3);
    chk("t4_last_once", n_last, 1);

    // full address space with random backpressure
    burst(4'd0, 5'd16, 2);
    chk("t5_last_once", n_last, 1);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end
endmodule

// File: doc/rom_burst_reader.md
Name: rom_burst_reader

Overview:
Read-side master for the team's synchronous 16x4 ROM (ports clk, en, addr, data; registered read, one-cycle latency). On a start command it walks a block of consecutive ROM addresses and drives rom_en/rom_addr. It captures rom_data and presents the words as a valid/ready stream with a last marker. A 2-entry output buffer absorbs the ROM latency under downstream backpressure, so the ROM is never read without room to store the result.

Parameters:
ADDR_W, 4, ROM address width; the address space is 2^ADDR_W words.
DATA_W, 4, ROM data width.

Ports:
clk  input  1  clock; all state updates on the rising edge.
rst_n  input  1  asynchronous active-low reset.
start  input  1  command strobe; sampled only in IDLE.
base_addr  input  ADDR_W  first ROM address of the burst; sampled with start.
length  input  ADDR_W+1  number of words, 0..2^ADDR_W; sampled with start.
busy  output  1  high from the cycle after start is accepted until the cycle done is high, inclusive.
done  output  1  one-cycle pulse at burst completion.
rom_en  output  1  ROM read enable.
rom_addr  output  ADDR_W  ROM read address.
rom_data  input  DATA_W  ROM read data; valid in the cycle after the rom_en cycle.
out_valid  output  1  stream word valid.
out_data  output  DATA_W  stream word.
out_last  output  1  high with the final word of the burst.
out_ready  input  1  downstream accept.

Behaviour:
- Reset (asynchronous, any time, including mid-burst):
  - state=IDLE; busy, done, rom_en, out_valid and out_last = 0; rom_addr and out_data = 0.
  - Buffer and in-flight flag cleared; pending ROM data is discarded.
- FSM states: IDLE, RUN, FIN.
  - IDLE: start=1 latches base_addr and length, and moves to RUN, or to FIN directly if length=0.
  - RUN: issues reads and drains the buffer. Moves to FIN on the edge where the last word is accepted (out_valid & out_ready & out_last).
  - FIN: done=1 for exactly one cycle, then IDLE.
  - start is ignored outside IDLE.
- Read issue (combinational from registered state):
  - rom_en=1 in RUN when words remain to issue and (occ + inflight − pop) < 2.
  - occ = buffer occupancy (0..2); inflight = a read was issued last cycle; pop = out_valid & out_ready.
  - rom_addr = next read address. It starts at base_addr, increments by 1 per issued read, and wraps modulo 2^ADDR_W (15 → 0). It holds its value when rom_en=0.
- Capture: when inflight=1, rom_data is written into the buffer at the end of that cycle.
- Latency:
  - start accepted at edge E0 → rom_en=1 in cycle 1 → data captured at E2 → out_valid=1 in cycle 3.
  - With out_ready held high, the stream sustains 1 word per cycle.
- Stream rules:
  - out_data and out_last stay stable while out_valid=1 and out_ready=0.
  - out_valid never depends on out_ready.
  - Words leave in address order; exactly `length` words are produced.
  - out_last=1 only on word number `length`.
- length = 2^ADDR_W (16): every address is read once, wrapping if base≠0.
- length = 0: no rom_en; done pulses in the cycle after start; busy high for that one cycle.
- Simultaneous capture and pop with occ=2 cannot occur, because the issue rule prevents it. A bench assertion flags overflow.

Test Plan:
- ROM model data = ~addr.
- Reset: hold rst_n=0 → all outputs 0. Assert rst_n=0 asynchronously mid-cycle during RUN → outputs drop immediately, no further rom_en.
- Basic burst with wrap: base=14, length=4, out_ready=1 → rom_addr 14,15,0,1 on consecutive cycles. out_data 1,0,F,E on cycles 3–6 with out_last on E. done one cycle after the E handshake.
- Backpressure: base=2, length=6, out_ready=0 for cycles 3–9 → at most 2 reads are issued (addr 2,3) then rom_en=0. out_data holds D. On release, words D,C,B,A,9,8 arrive in order with no loss or duplicates.
- Zero length: start with length=0 → no rom_en; done=1 in the cycle after start; no out_valid.
- Start while busy: a second start (base=0, length=3) during a length-5 burst → ignored. Exactly 5 words are produced and done pulses once.
- Full space: base=0, length=16, out_ready toggled randomly → all 16 words F..0 in order, out_last only on the 16th.
